// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared types and constants for the PS/2 host transmitter.
//   ps2_state_t : host-to-device frame sequencer states
//   CMD_*       : common mouse/keyboard command bytes
//   ACK_BYTE    : byte a device returns after accepting a command
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge -- 2-flop synchroniser plus registered falling-edge flag
// for one PS/2 line.
//   clk   : system clock
//   reset : async active-high reset; synchroniser presets to 1 (idle line)
//   pin   : raw line value
//   level : synchronised line value
//   fall  : one-cycle pulse, one cycle after level goes 1->0
module ps2_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta  <= 1'b1;
            level <= 1'b1;
            prev  <= 1'b1;
            fall  <= 1'b0;
        end else begin
            meta  <= pin;
            level <= meta;
            prev  <= level;
            fall  <= prev & ~level;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- sends one command byte from host to a PS/2 device.
//   clk, reset : system clock, async active-high reset
//   tx_start   : one-cycle send request, accepted only when idle
//   tx_data    : command byte, latched on acceptance
//   ps2clk     : open-drain PS/2 clock (only ever pulled low or released)
//   ps2data    : open-drain PS/2 data  (only ever pulled low or released)
//   tx_busy    : high while a frame is in progress
//   tx_done    : one-cycle pulse, device acknowledged the byte
//   tx_err     : one-cycle pulse, device NACKed or stopped clocking
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    inout  wire        ps2clk,
    inout  wire        ps2data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int TICK_DIV = (CLK_HZ / 1_000_000 > 0) ? CLK_HZ / 1_000_000 : 1;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W    = $clog2(INHIBIT_US + 1);
    localparam int TO_W     = $clog2(TIMEOUT_US + 1);

    ps2_state_t        state, state_nx;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DLY_W-1:0]  dly_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [2:0]        bit_cnt, bit_cnt_nx;
    logic [7:0]        shreg;
    logic              parity;
    logic              nack;
    logic              clk_oe, dat_oe;
    logic              clk_low_nx, dat_low_nx;
    logic              done_nx, err_nx;
    logic              timed, to_hit;
    logic              clk_lvl, clk_fall, dat_lvl, dat_fall;

    // Drivers are flops so reset releases the lines immediately and cleanly.
    assign ps2clk  = clk_oe ? 1'b0 : 1'bz;
    assign ps2data = dat_oe ? 1'b0 : 1'bz;
    assign tx_busy = (state != ST_IDLE);

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2clk),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (clk),
        .reset (reset),
        .pin   (ps2data),
        .level (dat_lvl),
        .fall  (dat_fall)
    );

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        timed      = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP) ||
                     (state == ST_ACK)  || (state == ST_WAIT_IDLE);
        // A device edge in the same cycle wins over the timeout.
        to_hit     = timed && tick && !clk_fall && (to_cnt == TO_W'(TIMEOUT_US - 1));

        case (state)
            ST_IDLE: begin
                bit_cnt_nx = 3'd0;
                if (tx_start) state_nx = ST_INHIBIT;
            end
            ST_INHIBIT: if (tick && dly_cnt == DLY_W'(INHIBIT_US - 1)) state_nx = ST_REQ;
            ST_REQ:     if (tick) state_nx = ST_DATA;
            ST_DATA: begin
                if (clk_fall) begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = ST_PARITY;
                end
            end
            ST_PARITY:  if (clk_fall) state_nx = ST_STOP;
            ST_STOP:    if (clk_fall) state_nx = ST_ACK;
            ST_ACK:     if (clk_fall) state_nx = ST_WAIT_IDLE;
            ST_WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    state_nx = ST_IDLE;
                    done_nx  = ~nack;
                    err_nx   = nack;
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (to_hit) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b0;
            err_nx   = 1'b1;
        end

        clk_low_nx = (state_nx == ST_INHIBIT) || (state_nx == ST_REQ);
        case (state_nx)
            ST_REQ:    dat_low_nx = 1'b1;
            ST_DATA:   dat_low_nx = ~shreg[bit_cnt_nx];
            ST_PARITY: dat_low_nx = ~parity;
            default:   dat_low_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            dly_cnt  <= '0;
            to_cnt   <= '0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'h00;
            parity   <= 1'b0;
            nack     <= 1'b0;
            clk_oe   <= 1'b0;
            dat_oe   <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            clk_oe  <= clk_low_nx;
            dat_oe  <= dat_low_nx;
            tx_done <= done_nx;
            tx_err  <= err_nx;

            // Prescaler restarts on every state change so each delay state
            // gets whole microseconds, and on device edges so the timeout is
            // measured from the last edge.
            if (tick || (state_nx != state) || (timed && clk_fall))
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TICK_W'(1);

            if (state_nx != state)
                dly_cnt <= '0;
            else if (tick && state == ST_INHIBIT)
                dly_cnt <= dly_cnt + DLY_W'(1);

            if (!timed || clk_fall)
                to_cnt <= '0;
            else if (tick)
                to_cnt <= to_cnt + TO_W'(1);

            if (state == ST_IDLE && tx_start) begin
                shreg  <= tx_data;
                parity <= ~^tx_data;
                nack   <= 1'b0;
            end else if (state == ST_ACK && clk_fall) begin
                nack   <= dat_lvl;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with a behavioural PS/2 device.
module tb_ps2_host_tx;

    localparam int CLK_HZ = 10_000_000;
    localparam int INH_US = 100;
    localparam int TO_US  = 100;
    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int H      = 20;   // device clock half period in cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        ps2clk;
    wire        ps2data;
    logic       tx_busy, tx_done, tx_err;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    assign ps2clk  = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2data = dev_dat_low ? 1'b0 : 1'bz;
    pullup (ps2clk);
    pullup (ps2data);

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int err_cyc = 0;
    int contention = 0;

    ps2_host_tx #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INH_US),
        .TIMEOUT_US (TO_US)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .ps2clk   (ps2clk),
        .ps2data  (ps2data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done) n_done <= n_done + 1;
        if (tx_err) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
        end
        // A host driving 1 against a device pulling low would not read 0.
        if ((dev_clk_low && ps2clk !== 1'b0) || (dev_dat_low && ps2data !== 1'b0))
            contention <= contention + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: 8 data bits LSB first, odd parity, stop bit released.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        int v;
        ones = 0;
        v = d;
        for (int i = 0; i < 8; i++) begin
            f[i] = (v % 2) == 1;
            ones += v % 2;
            v = v / 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // Device side of one frame. Samples each host bit just before the
    // falling edge that advances it; falls limits how many edges it makes.
    task automatic device_frame(input int falls, input logic ack_ok, input int inject_at,
                                input logic [7:0] inject_data, output logic [9:0] bits,
                                output int inh, output int last_fall, output logic ok);
        int t0, n;
        ok = 1'b1;
        bits = '0;
        inh = 0;
        last_fall = 0;
        n = 0;
        while (ps2clk !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        if (ps2clk !== 1'b0) begin ok = 1'b0; return; end
        t0 = cyc;
        n = 0;
        while (ps2data !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        if (ps2data !== 1'b0) begin ok = 1'b0; return; end
        inh = cyc - t0;
        n = 0;
        while (ps2clk !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        if (ps2clk !== 1'b1) begin ok = 1'b0; return; end
        repeat (H) @(negedge clk);
        for (int i = 0; i < falls && i < 11; i++) begin
            if (i == 10) begin
                dev_dat_low = ack_ok;
                repeat (H) @(negedge clk);
            end else begin
                bits[i] = (ps2data === 1'b1);
            end
            dev_clk_low = 1'b1;
            last_fall = cyc;
            if (i == inject_at) begin
                tx_data  = inject_data;
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_outcome(input int d0, input int e0, output int dd, output int de);
        int n;
        n = 0;
        while ((n_done + n_err) == (d0 + e0) && n < 3000) begin @(negedge clk); #1; n++; end
        repeat (5) @(negedge clk);
        #1;
        dd = n_done - d0;
        de = n_err - e0;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic ack_ok, input int inject_at);
        logic [9:0] bits, exp;
        int inh, lf, d0, e0, dd, de;
        logic ok;
        exp = frame_bits(d);
        d0 = n_done;
        e0 = n_err;
        start_tx(d);
        total++;
        if (tx_busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b want 1", name, tx_busy); end
        device_frame(11, ack_ok, inject_at, ~d, bits, inh, lf, ok);
        total++;
        if (ok !== 1'b1) begin bad++; $display("FAIL %s handshake: got %b want 1", name, ok); end
        total++;
        if (bits !== exp) begin bad++; $display("FAIL %s bits: got %b want %b", name, bits, exp); end
        total++;
        if (inh < INH_US * DIV) begin bad++; $display("FAIL %s inhibit_cycles: got %0d want >= %0d", name, inh, INH_US * DIV); end
        wait_outcome(d0, e0, dd, de);
        total++;
        if (dd !== (ack_ok ? 1 : 0) || de !== (ack_ok ? 0 : 1))
            begin bad++; $display("FAIL %s outcome: got done=%0d err=%0d want done=%0d err=%0d", name, dd, de, ack_ok ? 1 : 0, ack_ok ? 0 : 1); end
        total++;
        if (tx_busy !== 1'b0) begin bad++; $display("FAIL %s busy_after_end: got %b want 0", name, tx_busy); end
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || tx_done !== 1'b0 || tx_err !== 1'b0)
            begin bad++; $display("FAIL reset_outputs: got busy=%b done=%b err=%b want 000", tx_busy, tx_done, tx_err); end
        total++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1)
            begin bad++; $display("FAIL reset_lines: got clk=%b data=%b want 11", ps2clk, ps2data); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (tx_busy !== 1'b0 || ps2clk !== 1'b1 || ps2data !== 1'b1)
            begin bad++; $display("FAIL idle_after_reset: got busy=%b clk=%b data=%b want 0 1 1", tx_busy, ps2clk, ps2data); end
    endtask

    task automatic test_timeout;
        logic [9:0] bits, exp;
        int inh, lf, d0, e0, dd, de, dt;
        logic ok;
        exp = frame_bits(8'hA5);
        d0 = n_done;
        e0 = n_err;
        start_tx(8'hA5);
        device_frame(4, 1'b1, -1, 8'h00, bits, inh, lf, ok);
        total++;
        if (ok !== 1'b1 || bits[3:0] !== exp[3:0])
            begin bad++; $display("FAIL timeout_prefix: got ok=%b bits=%b want ok=1 bits=%b", ok, bits[3:0], exp[3:0]); end
        wait_outcome(d0, e0, dd, de);
        total++;
        if (dd !== 0 || de !== 1) begin bad++; $display("FAIL timeout_outcome: got done=%0d err=%0d want 0 1", dd, de); end
        dt = err_cyc - lf;
        total++;
        if (dt < TO_US * DIV - DIV || dt > TO_US * DIV + DIV + 8)
            begin bad++; $display("FAIL timeout_latency: got %0d cycles want %0d +/- %0d", dt, TO_US * DIV, DIV); end
        total++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1 || tx_busy !== 1'b0)
            begin bad++; $display("FAIL timeout_release: got clk=%b data=%b busy=%b want 1 1 0", ps2clk, ps2data, tx_busy); end
    endtask

    task automatic test_reset_mid;
        logic [9:0] bits;
        int inh, lf, glitches;
        logic ok;
        start_tx(8'h1C);          // bit 5 is 0, so data is held low when reset hits
        device_frame(5, 1'b1, -1, 8'h00, bits, inh, lf, ok);
        total++;
        if (ps2data !== 1'b0) begin bad++; $display("FAIL midframe_data_low: got %b want 0", ps2data); end
        reset = 1'b1;
        #1;
        total++;
        if (ps2clk !== 1'b1 || ps2data !== 1'b1 || tx_busy !== 1'b0)
            begin bad++; $display("FAIL reset_mid_release: got clk=%b data=%b busy=%b want 1 1 0", ps2clk, ps2data, tx_busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        glitches = 0;
        repeat (30) begin
            @(negedge clk);
            if (ps2clk !== 1'b1 || ps2data !== 1'b1) glitches++;
        end
        total++;
        if (glitches !== 0) begin bad++; $display("FAIL reset_mid_glitch: got %0d low samples want 0", glitches); end
        run_frame("after_reset_ff", 8'hFF, 1'b1, -1);
    endtask

    task automatic test_back_to_back;
        logic [7:0] d1, d2;
        logic [9:0] bits;
        int inh, lf, d0, e0, dd, de, n;
        logic ok;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        d0 = n_done;
        e0 = n_err;
        start_tx(d1);
        device_frame(11, 1'b1, -1, 8'h00, bits, inh, lf, ok);
        total++;
        if (bits !== frame_bits(d1)) begin bad++; $display("FAIL b2b_bits1: got %b want %b", bits, frame_bits(d1)); end
        n = 0;
        while (tx_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        tx_data  = d2;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        total++;
        if (tx_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", tx_busy); end
        device_frame(11, 1'b1, -1, 8'h00, bits, inh, lf, ok);
        total++;
        if (ok !== 1'b1 || bits !== frame_bits(d2))
            begin bad++; $display("FAIL b2b_bits2: got ok=%b bits=%b want 1 %b", ok, bits, frame_bits(d2)); end
        wait_outcome(d0 + 1, e0, dd, de);
        total++;
        if (n_done - d0 !== 2 || n_err - e0 !== 0)
            begin bad++; $display("FAIL b2b_outcome: got done=%0d err=%0d want 2 0", n_done - d0, n_err - e0); end
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic ack_ok;
        for (int k = 0; k < 6; k++) begin
            d = 8'($urandom);
            ack_ok = ($urandom_range(0, 3) != 0);
            run_frame($sformatf("rand%0d_%02h", k, d), d, ack_ok, -1);
        end
    endtask

    task automatic test_lines;
        total++;
        if (contention !== 0) begin bad++; $display("FAIL line_contention: got %0d want 0", contention); end
    endtask

    initial begin
        test_reset;
        run_frame("enable_f4", 8'hF4, 1'b1, -1);
        run_frame("zero_parity", 8'h00, 1'b1, -1);
        run_frame("nack_f3", 8'hF3, 1'b0, -1);
        test_timeout;
        run_frame("busy_ignore", 8'h5A, 1'b1, 5);
        test_reset_mid;
        test_random;
        test_back_to_back;
        test_lines;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the system clock frequency in Hz.
REQ-002 The block SHALL have parameter INHIBIT_US, default 100, meaning the clock-inhibit hold time in microseconds.
REQ-003 The block SHALL have parameter TIMEOUT_US, default 15000, meaning the maximum wait for any device clock edge before abort.
REQ-004 The block SHALL have port clk, input, 1 bit, system clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-006 The block SHALL have port tx_start, input, 1 bit, a one-cycle request to send tx_data.
REQ-007 The block SHALL have port tx_data, input, 8 bits, the command byte, sampled only on an accepted tx_start.
REQ-008 The block SHALL have port ps2clk, inout, 1 bit, PS/2 clock line, open-drain.
REQ-009 The block SHALL have port ps2data, inout, 1 bit, PS/2 data line, open-drain.
REQ-010 The block SHALL have port tx_busy, output, 1 bit, high from the cycle after acceptance until return to IDLE.
REQ-011 The block SHALL have port tx_done, output, 1 bit, a one-cycle pulse on successful acknowledged completion.
REQ-012 The block SHALL have port tx_err, output, 1 bit, a one-cycle pulse on NACK or timeout; it is exclusive with tx_done.

Function
REQ-013 ps2clk and ps2data SHALL only ever be driven 0 or released (Z), never driven 1.
REQ-014 Both lines SHALL pass through a 2-flop synchroniser, and a device falling edge SHALL be flagged one cycle after the synchronised value goes 1->0.
REQ-015 A microsecond tick SHALL be derived from CLK_HZ/1_000_000 cycles, and all delays SHALL be counted in ticks.
REQ-016 tx_start SHALL be accepted only in IDLE; a tx_start while busy SHALL be ignored with no state change.
REQ-017 State IDLE SHALL release both lines and hold tx_busy=0; on tx_start it SHALL latch tx_data, compute odd parity (~^tx_data) and go to INHIBIT.
REQ-018 State INHIBIT SHALL pull clk low with data released for INHIBIT_US ticks, then go to REQ.
REQ-019 State REQ SHALL pull data low while clk stays low for 1 tick, then release clk and go to DATA.
REQ-020 In state DATA, bit 0 SHALL be presented immediately on entry, the next bit SHALL be presented on each device falling edge (LSB first), and after the 8th falling edge the state SHALL go to PARITY.
REQ-021 State PARITY SHALL present the parity bit and go to STOP on the next falling edge.
REQ-022 State STOP SHALL release data and go to ACK on the next falling edge.
REQ-023 State ACK SHALL sample synchronised data on the next falling edge: 0 SHALL go to WAIT_IDLE, and 1 SHALL flag NACK and go to WAIT_IDLE.
REQ-024 State WAIT_IDLE SHALL wait until both synchronised lines are high, then pulse tx_done (or tx_err if NACK) and return to IDLE.
REQ-025 In DATA/PARITY/STOP/ACK/WAIT_IDLE, the timeout counter SHALL reset on every falling edge, and if it reaches TIMEOUT_US the block SHALL release both lines, pulse tx_err and go to IDLE.
REQ-026 Simultaneous timeout and falling edge in the same cycle SHALL give precedence to the edge.
REQ-027 tx_done/tx_err SHALL be asserted in the cycle the state returns to IDLE, and a new tx_start in that same cycle SHALL be accepted.
REQ-028 The bit counter SHALL be 3 bits, and the tick/timeout counters SHALL be sized with $clog2 of their terminal values without overflow.

Reset
REQ-029 Reset SHALL force IDLE, release both lines, clear tx_busy, tx_done, tx_err, all counters and the data/parity registers, and preset synchronisers to 1.
REQ-030 Reset asserted mid-frame SHALL release both lines within the same reset assertion, with no glitch low afterwards.

Structure
REQ-031 Package ps2_pkg SHALL hold the state enum and command constants (CMD_RESET 8'hFF, CMD_ENABLE 8'hF4, CMD_SET_RATE 8'hF3, ACK_BYTE 8'hFA).
REQ-032 Sub-module ps2_sync_edge SHALL implement the synchroniser and falling-edge detect for one line, instantiated twice.
REQ-033 The microsecond tick generator SHALL be inline and SHALL use reset (not an undeclared signal).

Verification
REQ-034 Sending tx_data=8'hF4 with a device model that ACKs SHALL produce data bits 0,0,1,0,1,1,1,1, parity 0, stop released, then tx_done pulse x1 and tx_err=0.
REQ-035 Sending tx_data=8'h00 SHALL produce parity bit 1, and ps2clk low ≥100 us before data goes low.
REQ-036 A device that drives ACK=1 SHALL produce tx_err pulse x1, no tx_done, and tx_busy low afterwards.
REQ-037 A device that stops clocking after bit 3 SHALL produce tx_err TIMEOUT_US +/-1 tick later with both lines released.
REQ-038 tx_start pulsed at bit 5 of an active frame SHALL be ignored, with the frame completing unchanged.
REQ-039 Reset asserted during DATA SHALL release both lines immediately, and the next tx_start with 8'hFF SHALL complete normally.
